// File: rtl/ysyx_24110015_mem_arbiter.sv
// Two-requester arbiter (IFU read-only, LSU read/write) in front of a single memory port.
// One transaction in flight: latch winner, hand request to memory, route the response back.
module ysyx_24110015_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR     = 1
) (
    input  logic                i_clock,
    input  logic                i_rst_n,
    input  logic                i_ifu_req_valid,
    output logic                o_ifu_req_ready,
    input  logic [ADDR_W-1:0]   i_ifu_addr,
    output logic                o_ifu_resp_valid,
    output logic [DATA_W-1:0]   o_ifu_rdata,
    input  logic                i_lsu_req_valid,
    output logic                o_lsu_req_ready,
    input  logic [ADDR_W-1:0]   i_lsu_addr,
    input  logic                i_lsu_wen,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_wmask,
    output logic                o_lsu_resp_valid,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic                i_mem_resp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner_lsu;
    logic                r_last_lsu;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;
    logic                r_mem_req_valid;
    logic                r_busy;

    logic w_idle;
    logic w_pick_lsu;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_resp;

    // Gating with i_rst_n keeps the ready outputs at 0 while reset is held.
    assign w_idle      = (r_state == S_IDLE) && i_rst_n;
    assign w_pick_lsu  = i_lsu_req_valid &&
                         (!i_ifu_req_valid || ((RR == 0) ? 1'b1 : !r_last_lsu));
    assign w_grant_lsu = w_idle && w_pick_lsu;
    assign w_grant_ifu = w_idle && i_ifu_req_valid && !w_pick_lsu;
    assign w_resp      = (r_state == S_WAIT) && i_mem_resp_valid;

    assign o_ifu_req_ready  = w_grant_ifu;
    assign o_lsu_req_ready  = w_grant_lsu;
    assign o_ifu_resp_valid = w_resp && !r_owner_lsu;
    assign o_lsu_resp_valid = w_resp && r_owner_lsu;
    assign o_ifu_rdata      = o_ifu_resp_valid ? i_mem_rdata : '0;
    assign o_lsu_rdata      = (o_lsu_resp_valid && !r_wen) ? i_mem_rdata : '0;

    assign o_mem_req_valid = r_mem_req_valid;
    assign o_mem_addr      = r_addr;
    assign o_mem_wen       = r_wen;
    assign o_mem_wdata     = r_wdata;
    assign o_mem_wmask     = r_wmask;
    assign o_busy          = r_busy;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_owner_lsu     <= 1'b0;
            r_last_lsu      <= 1'b1;
            r_addr          <= '0;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            r_mem_req_valid <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ifu || w_grant_lsu) begin
                        r_owner_lsu     <= w_grant_lsu;
                        r_last_lsu      <= w_grant_lsu;
                        r_addr          <= w_grant_lsu ? i_lsu_addr : i_ifu_addr;
                        r_wen           <= w_grant_lsu && i_lsu_wen;
                        r_wdata         <= w_grant_lsu ? i_lsu_wdata : '0;
                        r_wmask         <= w_grant_lsu ? i_lsu_wmask : '0;
                        r_mem_req_valid <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Responses cannot arrive before the request is taken, so none are looked at here.
                    if (i_mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_resp_valid) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_req_valid <= 1'b0;
                    r_busy          <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model; a second RR=0 instance checks fixed LSU priority.
module tb_ysyx_24110015_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          ifu_v, ifu_rdy, ifu_rv;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_v, lsu_rdy, lsu_wen, lsu_rv;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_v, mem_rdy, mem_wen, mem_rspv, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    logic          b_rst_n;
    logic          b_ifu_v, b_ifu_rdy, b_ifu_rv;
    logic [AW-1:0] b_ifu_addr;
    logic [DW-1:0] b_ifu_rdata;
    logic          b_lsu_v, b_lsu_rdy, b_lsu_wen, b_lsu_rv;
    logic [AW-1:0] b_lsu_addr;
    logic [DW-1:0] b_lsu_wdata, b_lsu_rdata;
    logic [MW-1:0] b_lsu_wmask;
    logic          b_mem_v, b_mem_rdy, b_mem_wen, b_mem_rspv, b_busy;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata;
    logic [MW-1:0] b_mem_wmask;

    ysyx_24110015_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) dut (
        .i_clock(clk), .i_rst_n(rst_n),
        .i_ifu_req_valid(ifu_v), .o_ifu_req_ready(ifu_rdy), .i_ifu_addr(ifu_addr),
        .o_ifu_resp_valid(ifu_rv), .o_ifu_rdata(ifu_rdata),
        .i_lsu_req_valid(lsu_v), .o_lsu_req_ready(lsu_rdy), .i_lsu_addr(lsu_addr),
        .i_lsu_wen(lsu_wen), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
        .o_lsu_resp_valid(lsu_rv), .o_lsu_rdata(lsu_rdata),
        .o_mem_req_valid(mem_v), .i_mem_req_ready(mem_rdy), .o_mem_addr(mem_addr),
        .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
        .i_mem_resp_valid(mem_rspv), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    ysyx_24110015_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) dut_fixed (
        .i_clock(clk), .i_rst_n(b_rst_n),
        .i_ifu_req_valid(b_ifu_v), .o_ifu_req_ready(b_ifu_rdy), .i_ifu_addr(b_ifu_addr),
        .o_ifu_resp_valid(b_ifu_rv), .o_ifu_rdata(b_ifu_rdata),
        .i_lsu_req_valid(b_lsu_v), .o_lsu_req_ready(b_lsu_rdy), .i_lsu_addr(b_lsu_addr),
        .i_lsu_wen(b_lsu_wen), .i_lsu_wdata(b_lsu_wdata), .i_lsu_wmask(b_lsu_wmask),
        .o_lsu_resp_valid(b_lsu_rv), .o_lsu_rdata(b_lsu_rdata),
        .o_mem_req_valid(b_mem_v), .i_mem_req_ready(b_mem_rdy), .o_mem_addr(b_mem_addr),
        .o_mem_wen(b_mem_wen), .o_mem_wdata(b_mem_wdata), .o_mem_wmask(b_mem_wmask),
        .i_mem_resp_valid(b_mem_rspv), .i_mem_rdata(b_mem_rdata), .o_busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Transaction-level model: is a transaction open, has memory taken it, who owns it.
    bit            m_busy, m_issued, m_owner_lsu, m_last_lsu;
    logic [AW-1:0] m_addr;
    bit            m_wen;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    bit            acc_ifu, acc_lsu;
    logic          s_ifu_rdy, s_lsu_rdy, s_ifu_rv, s_lsu_rv;
    logic [DW-1:0] s_ifu_rdata, s_lsu_rdata;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issued = 0; m_owner_lsu = 0; m_last_lsu = 1;
        m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
        acc_ifu = 0; acc_lsu = 0;
    endtask

    // One clock: inputs are already driven; check at negedge, advance model at posedge.
    task automatic cycle();
        bit idle, win_lsu, e_ifu_rdy, e_lsu_rdy, e_resp;
        @(negedge clk);
        idle      = !m_busy;
        win_lsu   = lsu_v && (!ifu_v || !m_last_lsu);
        e_ifu_rdy = idle && ifu_v && !win_lsu;
        e_lsu_rdy = idle && win_lsu;
        e_resp    = m_busy && m_issued && mem_rspv;
        s_ifu_rdy = ifu_rdy; s_lsu_rdy = lsu_rdy; s_ifu_rv = ifu_rv; s_lsu_rv = lsu_rv;
        s_ifu_rdata = ifu_rdata; s_lsu_rdata = lsu_rdata;
        check("ifu_req_ready", ifu_rdy, e_ifu_rdy);
        check("lsu_req_ready", lsu_rdy, e_lsu_rdy);
        check("mem_req_valid", mem_v, m_busy && !m_issued);
        check("busy", busy, m_busy);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wen", mem_wen, m_wen);
        check("mem_wdata", mem_wdata, m_wdata);
        check("mem_wmask", mem_wmask, m_wmask);
        check("ifu_resp_valid", ifu_rv, e_resp && !m_owner_lsu);
        check("ifu_rdata", ifu_rdata, (e_resp && !m_owner_lsu) ? mem_rdata : '0);
        check("lsu_resp_valid", lsu_rv, e_resp && m_owner_lsu);
        check("lsu_rdata", lsu_rdata, (e_resp && m_owner_lsu && !m_wen) ? mem_rdata : '0);
        @(posedge clk);
        acc_ifu = e_ifu_rdy;
        acc_lsu = e_lsu_rdy;
        if (e_ifu_rdy || e_lsu_rdy) begin
            m_busy = 1; m_issued = 0;
            m_owner_lsu = e_lsu_rdy; m_last_lsu = e_lsu_rdy;
            m_addr  = e_lsu_rdy ? lsu_addr : ifu_addr;
            m_wen   = e_lsu_rdy && lsu_wen;
            m_wdata = e_lsu_rdy ? lsu_wdata : '0;
            m_wmask = e_lsu_rdy ? lsu_wmask : '0;
        end else if (m_busy && !m_issued && mem_rdy) begin
            m_issued = 1;
        end else if (e_resp) begin
            m_busy = 0;
            n_txn++;
            $display("txn %0d: %s addr=0x%08h wen=%0d rdata=0x%08h", n_txn,
                     m_owner_lsu ? "LSU" : "IFU", m_addr, m_wen,
                     m_wen ? 32'h0 : mem_rdata);
        end
        #1;
    endtask

    initial begin
        bit ifu_pend, lsu_pend, was_issued;
        int mem_dly;
        rst_n = 0; b_rst_n = 0;
        ifu_v = 0; ifu_addr = '0; lsu_v = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_rdy = 0; mem_rspv = 0; mem_rdata = '0;
        b_ifu_v = 0; b_ifu_addr = '0; b_lsu_v = 0; b_lsu_addr = '0; b_lsu_wen = 0;
        b_lsu_wdata = '0; b_lsu_wmask = '0; b_mem_rdy = 0; b_mem_rspv = 0; b_mem_rdata = '0;
        model_reset();

        // Reset state, with requests pending during reset
        repeat (2) @(posedge clk);
        #1 ifu_v = 1; lsu_v = 1;
        #1;
        check("rst_ifu_ready", ifu_rdy, 0);
        check("rst_lsu_ready", lsu_rdy, 0);
        check("rst_mem_req_valid", mem_v, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        ifu_v = 0; lsu_v = 0;
        @(negedge clk) rst_n = 1; b_rst_n = 1;
        @(posedge clk) #1;

        // Tie after reset: IFU first; IFU read 0x8000_0000 returns 0x0000_0413
        ifu_v = 1; ifu_addr = 32'h8000_0000;
        lsu_v = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
        mem_rdy = 1; mem_rdata = 32'h0000_0413;
        cycle();
        check("tie1_ifu_wins", s_ifu_rdy, 1);
        check("tie1_lsu_waits", s_lsu_rdy, 0);
        ifu_v = 0;
        cycle();
        mem_rspv = 1;
        cycle();
        check("t1_ifu_resp_valid", s_ifu_rv, 1);
        check("t1_ifu_rdata", s_ifu_rdata, 32'h0000_0413);
        mem_rspv = 0;
        cycle();
        check("tie1_lsu_next", s_lsu_rdy, 1);
        lsu_v = 0;
        cycle();
        mem_rspv = 1; mem_rdata = 32'h1234_5678;
        cycle();
        check("lsu_read_rdata", s_lsu_rdata, 32'h1234_5678);
        mem_rspv = 0;
        ifu_v = 1; lsu_v = 1; ifu_addr = 32'h8000_0004;
        cycle();
        check("tie2_ifu_again", s_ifu_rdy, 1);
        ifu_v = 0;
        cycle();
        mem_rspv = 1;
        cycle();
        mem_rspv = 0;
        cycle();
        check("tie2_lsu_after", s_lsu_rdy, 1);
        lsu_v = 0;
        cycle();
        mem_rspv = 1;
        cycle();
        mem_rspv = 0;

        // LSU write with memory stalling 3 cycles; requester fields change after accept
        lsu_v = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        mem_rdy = 0;
        cycle();
        check("t3_accept", s_lsu_rdy, 1);
        lsu_v = 0; lsu_addr = 32'h0BAD_0BAD; lsu_wdata = 32'h5555_AAAA; lsu_wmask = 4'h3;
        for (int i = 0; i < 3; i++) begin
            mem_rspv = (i == 1);
            cycle();
            check("t3_hold_addr", mem_addr, 32'h8000_1000);
            check("t3_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("t3_hold_valid", mem_v, 1);
        end
        mem_rspv = 0; mem_rdy = 1;
        cycle();
        mem_rdy = 0; mem_rspv = 1; mem_rdata = 32'hFFFF_FFFF;
        cycle();
        check("t3_resp_valid", s_lsu_rv, 1);
        check("t3_write_rdata", s_lsu_rdata, 0);
        cycle();
        check("idle_resp_ignored", s_lsu_rv, 0);
        mem_rspv = 0;

        // Reset while waiting for the response
        ifu_v = 1; ifu_addr = 32'h8000_0040; mem_rdy = 1;
        cycle();
        ifu_v = 0;
        cycle();
        ifu_v = 1; mem_rspv = 1; mem_rdata = 32'hCAFE_F00D;
        #1 rst_n = 0;
        #1;
        check("t5_ifu_resp_valid", ifu_rv, 0);
        check("t5_ifu_rdata", ifu_rdata, 0);
        check("t5_busy", busy, 0);
        check("t5_ifu_ready", ifu_rdy, 0);
        check("t5_mem_req_valid", mem_v, 0);
        check("t5_mem_addr", mem_addr, 0);
        model_reset();
        @(posedge clk) #1;
        rst_n = 1; ifu_v = 0;
        cycle();
        check("t5_post_reset_resp", s_ifu_rv, 0);
        mem_rspv = 0;

        // Randomized traffic
        ifu_pend = 0; lsu_pend = 0; mem_dly = 0;
        for (int c = 0; c < 3000; c++) begin
            if (acc_ifu) ifu_pend = 0;
            if (acc_lsu) lsu_pend = 0;
            if (!ifu_pend) begin
                ifu_addr = $urandom() & 32'hFFFF_FFFC;
                ifu_pend = ($urandom_range(0, 2) == 0);
            end
            if (!lsu_pend) begin
                lsu_addr  = $urandom() & 32'hFFFF_FFFC;
                lsu_wen   = 1'($urandom_range(0, 1));
                lsu_wdata = $urandom();
                lsu_wmask = 4'($urandom_range(0, 15));
                lsu_pend  = ($urandom_range(0, 2) == 0);
            end
            ifu_v = ifu_pend; lsu_v = lsu_pend;
            mem_rdy   = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom();
            if (m_busy && m_issued) begin
                if (mem_dly == 0) mem_rspv = 1;
                else begin mem_rspv = 0; mem_dly--; end
            end else begin
                mem_rspv = ($urandom_range(0, 4) == 0);
            end
            was_issued = m_busy && m_issued;
            cycle();
            if (m_busy && m_issued && !was_issued) mem_dly = $urandom_range(0, 3);
        end
        ifu_v = 0; lsu_v = 0; mem_rspv = 0;

        // Fixed-priority instance: LSU wins every tie
        for (int k = 0; k < 4; k++) begin
            b_ifu_v = 1; b_ifu_addr = 32'h8000_0000 + 32'(k * 4);
            b_lsu_v = 1; b_lsu_addr = 32'h8000_3000; b_lsu_wen = 0;
            b_mem_rdy = 1; b_mem_rspv = 0;
            @(negedge clk);
            check("rr0_lsu_ready", b_lsu_rdy, 1);
            check("rr0_ifu_ready", b_ifu_rdy, 0);
            @(posedge clk) #1;
            @(posedge clk) #1;
            b_mem_rspv = 1; b_mem_rdata = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            check("rr0_lsu_resp", b_lsu_rv, 1);
            check("rr0_ifu_resp", b_ifu_rv, 0);
            check("rr0_lsu_rdata", b_lsu_rdata, 32'hA000_0000 + 32'(k));
            @(posedge clk) #1;
            b_mem_rspv = 0;
            $display("txn rr0 %0d: LSU won tie", k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
